ovl_fire_arbiter: RTL and testbench
===================================

OVL_FIRE_ARBITER -- requirements
Module: ovl_fire_arbiter

Interface
REQ-001 Parameter NUM_CHK, default 4: number of checker fire inputs, range 2..16.
REQ-002 Parameter ID_W, default 2: width of the report id, equal to clog2(NUM_CHK).
REQ-003 Parameter CNT_W, default 8: width of the total-fire counter.
REQ-004 Parameter MAX_REPORT, default 15: per-checker report quota, used only when OVL_FIRE_LIMIT_EN is defined.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  when 1, accept new fires; when 0, ignore new fires.
REQ-008 fire  input  NUM_CHK  per-checker fire pulse; level is sampled every cycle.
REQ-009 rpt_valid  output  1  report available.
REQ-010 rpt_ready  input  1  report consumer accepts.
REQ-011 rpt_id  output  ID_W  index of the reported checker.
REQ-012 pending  output  NUM_CHK  latched, not-yet-reported fires.
REQ-013 fire_total  output  CNT_W  saturating count of accepted fires.
REQ-014 lost  output  1  sticky flag: a fire arrived for an already-pending checker.
REQ-015 quota_hit  output  NUM_CHK  checker has exhausted its report quota.

Function
REQ-016 An accepted fire SHALL satisfy all of: enable=1, fire[i]=1, and checker i not blocked by quota.
- An accepted fire SHALL set pending[i] at the next edge.
REQ-017 fire_total SHALL add the number of accepted fires in a cycle, popcount of the accepted vector.
- It SHALL saturate at 2^CNT_W-1.
REQ-018 lost SHALL set when fire[i] is accepted while pending[i]=1 and pending[i] is not being cleared that cycle.
- lost SHALL stay set until reset.
REQ-019 FSM states SHALL be IDLE and PRESENT.
- rpt_valid SHALL be 1 exactly in PRESENT.
REQ-020 IDLE -> PRESENT SHALL occur when pending is nonzero.
- rpt_id SHALL be loaded with the first set pending bit at or after the round-robin pointer rr_ptr, searching upward modulo NUM_CHK.
REQ-021 In PRESENT with rpt_ready=0, rpt_id SHALL hold stable and rpt_valid SHALL stay 1.
REQ-022 In PRESENT with rpt_ready=1, the block SHALL:
- clear pending[rpt_id];
- set rr_ptr to rpt_id+1, wrapping NUM_CHK-1 -> 0;
- return to IDLE.
REQ-023 A fire on checker rpt_id in the same cycle as its handshake SHALL leave pending[rpt_id]=1.
- That case SHALL NOT set lost.
REQ-024 Report latency SHALL be: fire at edge N sets pending at N+1; rpt_valid=1 after edge N+2 when IDLE.
- Maximum throughput SHALL be one report per two cycles.
REQ-025 enable=0 SHALL NOT abort a report in PRESENT or clear pending bits.
- Pending bits SHALL still be reported.

Reset
REQ-026 reset=1 SHALL force, at the next edge: state=IDLE, rpt_valid=0, rpt_id=0, rr_ptr=0, pending=0, fire_total=0, lost=0, quota counters=0, quota_hit=0.
REQ-027 Reset asserted during PRESENT SHALL drop rpt_valid at the next edge without a handshake.
REQ-028 Reset SHALL take priority over fires and handshakes in the same cycle.

Configuration
REQ-029 With macro OVL_FIRE_LIMIT_EN defined:
- each checker SHALL keep a report counter, incremented on each completed handshake for that checker;
- quota_hit[i] SHALL set when its counter reaches MAX_REPORT;
- further fires of that checker SHALL be blocked: not accepted, not counted, never set lost;
- a pending bit already latched SHALL still be reported.
REQ-030 Without OVL_FIRE_LIMIT_EN:
- no quota counters SHALL exist;
- quota_hit SHALL be constant 0;
- no fire SHALL be blocked.

Verification
REQ-031 The bench SHALL cover: single fire[2] pulse, rpt_ready=1 -> rpt_valid high two cycles later with rpt_id=2; then pending=0, fire_total=1.
REQ-032 The bench SHALL cover: fire=4'b1111 in one cycle, rpt_ready=1 -> fire_total=4; reports in order ids 0,1,2,3, one per two cycles; lost=0.
REQ-033 The bench SHALL cover: fire[1] pending, rpt_ready held 0 five cycles, fire[1] again -> rpt_id=1 held stable throughout; lost=1.
REQ-034 The bench SHALL cover: fire[3] in the handshake cycle of id 3 -> pending[3] stays 1, a second report of id 3 follows, lost=0.
REQ-035 The bench SHALL cover: reset=1 while rpt_valid=1 -> next cycle rpt_valid=0, pending=0, fire_total=0, lost=0.
REQ-036 The bench SHALL cover: OVL_FIRE_LIMIT_EN defined, MAX_REPORT=2, 3 separated fires on checker 0 -> 2 reports, quota_hit[0]=1, fire_total=2.

Source files
------------

// File: rtl/ovl_fire_arbiter.sv
// Round-robin arbiter that latches checker fire pulses and presents them one at a time as reports.
// Optional per-checker report quota is enabled by defining OVL_FIRE_LIMIT_EN.
module ovl_fire_arbiter #(
  parameter int NUM_CHK    = 4,
  parameter int ID_W       = 2,
  parameter int CNT_W      = 8,
  parameter int MAX_REPORT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_CHK-1:0] fire,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [ID_W-1:0]    rpt_id,
  output logic [NUM_CHK-1:0] pending,
  output logic [CNT_W-1:0]   fire_total,
  output logic               lost,
  output logic [NUM_CHK-1:0] quota_hit
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_e;

  localparam int SUM_W = CNT_W + 5;
  localparam logic [SUM_W-1:0] SAT = SUM_W'({CNT_W{1'b1}});

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rpt_id_q, rpt_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_CHK-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]   fire_total_q, fire_total_d;
  logic               lost_q, lost_d;

  logic               handshake;
  logic [NUM_CHK-1:0] accepted;
  logic [NUM_CHK-1:0] clr;
  logic [SUM_W-1:0]   pop;
  logic [SUM_W-1:0]   sum;
  logic [ID_W:0]      srch_idx;
  logic               found;

  // Datapath: fire acceptance, pending latch, lost flag and saturating total.
  always_comb begin
    handshake = (state_q == PRESENT) && rpt_ready;
    accepted  = enable ? (fire & ~quota_hit) : '0;
    clr       = '0;
    for (int unsigned i = 0; i < NUM_CHK; i++) begin
      if (handshake && (rpt_id_q == ID_W'(i))) clr[i] = 1'b1;
    end
    // A re-fire of the checker being acknowledged re-latches and is not a loss.
    pending_d = (pending_q & ~clr) | accepted;
    lost_d    = lost_q | (|(accepted & pending_q & ~clr));
    pop       = '0;
    for (int unsigned i = 0; i < NUM_CHK; i++) begin
      pop = pop + SUM_W'(accepted[i]);
    end
    sum          = SUM_W'(fire_total_q) + pop;
    fire_total_d = (sum > SAT) ? '1 : sum[CNT_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    rpt_id_d = rpt_id_q;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    srch_idx = '0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d = PRESENT;
          for (int unsigned k = 0; k < NUM_CHK; k++) begin
            srch_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (srch_idx >= (ID_W+1)'(NUM_CHK)) srch_idx = srch_idx - (ID_W+1)'(NUM_CHK);
            if (!found && pending_q[srch_idx[ID_W-1:0]]) begin
              found    = 1'b1;
              rpt_id_d = srch_idx[ID_W-1:0];
            end
          end
        end
      end
      PRESENT: begin
        if (rpt_ready) begin
          state_d  = IDLE;
          rr_ptr_d = (rpt_id_q == ID_W'(NUM_CHK-1)) ? '0 : rpt_id_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rpt_id_q     <= '0;
      rr_ptr_q     <= '0;
      pending_q    <= '0;
      fire_total_q <= '0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rpt_id_q     <= rpt_id_d;
      rr_ptr_q     <= rr_ptr_d;
      pending_q    <= pending_d;
      fire_total_q <= fire_total_d;
      lost_q       <= lost_d;
    end
  end

`ifdef OVL_FIRE_LIMIT_EN
  localparam int QW = $clog2(MAX_REPORT + 1);

  logic [QW-1:0] qcnt_q [NUM_CHK];
  logic [QW-1:0] qcnt_d [NUM_CHK];
  logic [NUM_CHK-1:0] hit;

  // Counters stop at the quota; a latched pending bit is still reported past it.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CHK; i++) begin
      hit[i]    = (qcnt_q[i] >= QW'(MAX_REPORT));
      qcnt_d[i] = qcnt_q[i];
      if (clr[i] && !hit[i]) qcnt_d[i] = qcnt_q[i] + QW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CHK; i++) begin
      if (reset) qcnt_q[i] <= '0;
      else       qcnt_q[i] <= qcnt_d[i];
    end
  end

  assign quota_hit = hit;
`else
  assign quota_hit = '0;
`endif

  assign rpt_valid  = (state_q == PRESENT);
  assign rpt_id     = rpt_id_q;
  assign pending    = pending_q;
  assign fire_total = fire_total_q;
  assign lost       = lost_q;

endmodule

// File: tb/tb_ovl_fire_arbiter.sv
// Directed bench for ovl_fire_arbiter: scoreboard of expected report ids popped on each handshake.
module tb_ovl_fire_arbiter;

`ifdef OVL_FIRE_LIMIT_EN
  localparam int MAXR = 2;
  localparam int QUOTA_REPORTS = 2;
`else
  localparam int MAXR = 15;
  localparam int QUOTA_REPORTS = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] fire;
  logic       rpt_valid;
  logic       rpt_ready;
  logic [1:0] rpt_id;
  logic [3:0] pending;
  logic [7:0] fire_total;
  logic       lost;
  logic [3:0] quota_hit;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  ovl_fire_arbiter #(
    .NUM_CHK   (4),
    .ID_W      (2),
    .CNT_W     (8),
    .MAX_REPORT(MAXR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .fire      (fire),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_id    (rpt_id),
    .pending   (pending),
    .fire_total(fire_total),
    .lost      (lost),
    .quota_hit (quota_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    reset     = 1'b1;
    fire      = '0;
    rpt_ready = 1'b0;
    tick(1);
    reset = 1'b0;
  endtask

  // Every handshake seen before the next rising edge must match the oldest expected id.
  always @(negedge clk) begin
    if (reset === 1'b0 && rpt_valid === 1'b1 && rpt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_report", {30'd0, rpt_id}, 32'hFFFF_FFFF);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("sb_rpt_id", {30'd0, rpt_id}, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    fire      = '0;
    rpt_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    check("rst_valid", rpt_valid, 0);
    check("rst_id", rpt_id, 0);
    check("rst_pending", pending, 0);
    check("rst_total", fire_total, 0);
    check("rst_lost", lost, 0);
    check("rst_quota", quota_hit, 0);

    // Single fire on checker 2
    enable    = 1'b1;
    rpt_ready = 1'b1;
    fire      = 4'b0100;
    exp_q.push_back(2);
    tick(1);
    fire = '0;
    check("t1_pending", pending, 4'b0100);
    check("t1_valid_early", rpt_valid, 0);
    tick(1);
    check("t1_valid", rpt_valid, 1);
    check("t1_id", rpt_id, 2);
    tick(1);
    check("t1_valid_after", rpt_valid, 0);
    check("t1_pending_after", pending, 0);
    check("t1_total", fire_total, 1);

    // All four fire at once: round-robin from 0, one report per two cycles
    reset_dut();
    rpt_ready = 1'b1;
    fire      = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    tick(1);
    fire = '0;
    check("t2_total", fire_total, 4);
    tick(1);
    for (int k = 0; k < 4; k++) begin
      check("t2_valid", rpt_valid, 1);
      check("t2_id", rpt_id, k);
      tick(1);
      check("t2_gap", rpt_valid, 0);
      tick(1);
    end
    check("t2_pending", pending, 0);
    check("t2_lost", lost, 0);
    check("t2_sb_empty", exp_q.size(), 0);

    // Stall with re-fire of the pending checker
    reset_dut();
    fire = 4'b0010;
    exp_q.push_back(1);
    tick(1);
    fire = '0;
    tick(1);
    for (int c = 0; c < 5; c++) begin
      check("t3_valid", rpt_valid, 1);
      check("t3_id", rpt_id, 1);
      if (c == 1) fire = 4'b0010;
      tick(1);
      fire = '0;
    end
    check("t3_lost", lost, 1);
    check("t3_id_end", rpt_id, 1);
    check("t3_pending", pending, 4'b0010);
    rpt_ready = 1'b1;
    tick(1);
    rpt_ready = 1'b0;
    check("t3_valid_after", rpt_valid, 0);
    check("t3_pending_after", pending, 0);
    check("t3_lost_sticky", lost, 1);
    check("t3_total", fire_total, 2);

    // Re-fire during the handshake of the same checker
    reset_dut();
    fire = 4'b1000;
    exp_q.push_back(3);
    tick(1);
    fire = '0;
    tick(1);
    check("t4_valid", rpt_valid, 1);
    check("t4_id", rpt_id, 3);
    rpt_ready = 1'b1;
    fire      = 4'b1000;
    exp_q.push_back(3);
    tick(1);
    fire = '0;
    check("t4_pending_kept", pending, 4'b1000);
    check("t4_lost", lost, 0);
    check("t4_gap", rpt_valid, 0);
    tick(1);
    check("t4_valid2", rpt_valid, 1);
    check("t4_id2", rpt_id, 3);
    tick(1);
    check("t4_pending_after", pending, 0);
    check("t4_lost_after", lost, 0);
    check("t4_total", fire_total, 2);
    check("t4_sb_empty", exp_q.size(), 0);

    // Reset while presenting, with a fire in the reset cycle
    reset_dut();
    fire = 4'b0001;
    tick(2);
    fire = '0;
    check("t5_valid", rpt_valid, 1);
    check("t5_lost", lost, 1);
    check("t5_total", fire_total, 2);
    reset     = 1'b1;
    fire      = 4'b0010;
    rpt_ready = 1'b1;
    tick(1);
    check("t5_valid_rst", rpt_valid, 0);
    check("t5_pending_rst", pending, 0);
    check("t5_total_rst", fire_total, 0);
    check("t5_lost_rst", lost, 0);
    check("t5_id_rst", rpt_id, 0);
    reset     = 1'b0;
    fire      = '0;
    rpt_ready = 1'b0;
    tick(1);
    check("t5_idle", rpt_valid, 0);

    // enable=0 ignores fires
    reset_dut();
    enable = 1'b0;
    fire   = 4'b1111;
    tick(2);
    fire = '0;
    check("t6_pending", pending, 0);
    check("t6_total", fire_total, 0);
    check("t6_valid", rpt_valid, 0);
    enable = 1'b1;

    // Saturation of fire_total at 255
    reset_dut();
    fire = 4'b1111;
    tick(63);
    check("t7_total_252", fire_total, 252);
    tick(1);
    check("t7_total_sat", fire_total, 255);
    tick(3);
    check("t7_total_hold", fire_total, 255);
    fire = '0;

    // Quota on checker 0: three separated fires
    reset_dut();
    rpt_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      fire = 4'b0001;
      if (n < QUOTA_REPORTS) exp_q.push_back(0);
      tick(1);
      fire = '0;
      check("t8_pending", pending, (n < QUOTA_REPORTS) ? 4'b0001 : 4'b0000);
      tick(3);
    end
    check("t8_quota", quota_hit, (QUOTA_REPORTS == 2) ? 4'b0001 : 4'b0000);
    check("t8_total", fire_total, QUOTA_REPORTS);
    check("t8_lost", lost, 0);
    check("t8_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
